cdb_arbiter: RTL and testbench

- Collects completed results (tag + 32-bit data) from the execution units.
- Buffers them in a small FIFO per source.
- Broadcasts at most one result per cycle on the common data bus (CDB).
- Drives the `cdb_valid`/`cdb_tag`/`cdb_data` lines that every reservation station and the register status table snoop for operand wake-up; sits between the functional-unit write-back ports and all CDB consumers.

---
 rtl/cdb_arbiter.sv | 158 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-source result FIFOs with a round-robin arbiter onto the common data bus (optional CDB_ARB_PRIO0_EN)
module cdb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          cdb_valid,
    output logic [TAG_WIDTH-1:0]          cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_data,
    output logic [NUM_SRC-1:0]            cdb_src
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(NUM_SRC);
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [SW:0]   NSRC_C   = (SW+1)'(NUM_SRC);
    localparam logic [SW-1:0] LAST_SRC = SW'(NUM_SRC - 1);

    logic [TAG_WIDTH-1:0]  mem_tag  [NUM_SRC][BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [NUM_SRC][BUF_DEPTH];
    logic [CW-1:0]         count    [NUM_SRC];
    logic [AW-1:0]         wptr     [NUM_SRC];
    logic [AW-1:0]         rptr     [NUM_SRC];
    logic [SW-1:0]         rr_ptr;
    logic [SW-1:0]         rr_next;
    logic                  rr_upd;

    logic [NUM_SRC-1:0]    nonempty;
    logic [NUM_SRC-1:0]    push;
    logic [NUM_SRC-1:0]    pop;
    logic                  grant_valid;
    logic [SW-1:0]         grant_idx;
    logic [SW:0]           search_sum;
    logic [SW-1:0]         search_idx;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        nonempty  = '0;
        src_ready = '0;
        push      = '0;
        pop       = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            nonempty[s]  = (count[s] != '0);
            src_ready[s] = i_rst_n && !flush && (count[s] < DEPTH_C);
            push[s]      = src_valid[s] && src_ready[s];
            pop[s]       = grant_valid && (grant_idx == SW'(s));
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        search_sum  = '0;
        search_idx  = '0;
`ifdef CDB_ARB_PRIO0_EN
        grant_valid = nonempty[0];
`endif
        for (int i = 0; i < NUM_SRC; i++) begin
            search_sum = {1'b0, rr_ptr} + (SW+1)'(i);
            if (search_sum >= NSRC_C) begin
                search_sum = search_sum - NSRC_C;
            end
            search_idx = search_sum[SW-1:0];
`ifdef CDB_ARB_PRIO0_EN
            if (!grant_valid && (search_idx != '0) && nonempty[search_idx]) begin
`else
            if (!grant_valid && nonempty[search_idx]) begin
`endif
                grant_valid = 1'b1;
                grant_idx   = search_idx;
            end
        end
    end

    always_comb begin
        rr_next = (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
`ifdef CDB_ARB_PRIO0_EN
        rr_upd  = grant_valid && (grant_idx != '0);
`else
        rr_upd  = grant_valid;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count[s] <= '0;
                wptr[s]  <= '0;
                rptr[s]  <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                count[s] <= '0;
                wptr[s]  <= '0;
                rptr[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) begin
                    wptr[s] <= wptr[s] + 1'b1;
                end
                if (pop[s]) begin
                    rptr[s] <= rptr[s] + 1'b1;
                end
                if (push[s] && !pop[s]) begin
                    count[s] <= count[s] + 1'b1;
                end else if (!push[s] && pop[s]) begin
                    count[s] <= count[s] - 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                mem_tag[s][wptr[s]]  <= src_tag[s*TAG_WIDTH +: TAG_WIDTH];
                mem_data[s][wptr[s]] <= src_data[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (grant_valid) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= mem_tag[grant_idx][rptr[grant_idx]];
            cdb_data  <= mem_data[grant_idx][rptr[grant_idx]];
            cdb_src   <= NUM_SRC'(1) << grant_idx;
            if (rr_upd) begin
                rr_ptr <= rr_next;
            end
        end else begin
            cdb_valid <= 1'b0;
            cdb_src   <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter against a queue-based reference model
module tb_cdb_arbiter;

    localparam int NS = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int BD = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS*TW-1:0]  src_tag;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_ready;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [NS-1:0]     cdb_src;

    cdb_arbiter #(.NUM_SRC(NS), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data), .src_ready(src_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int src; logic [TW-1:0] tag; logic [DW-1:0] data; } ent_t;
    typedef struct { logic [TW-1:0] tag; logic [DW-1:0] data; logic [NS-1:0] src; } bc_t;

    ent_t mq[$];
    bc_t  expq[$];
    int   rr;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [NS-1:0] pv;
    logic [TW-1:0] pt [NS];
    logic [DW-1:0] pd [NS];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int mcount(input int s);
        int n = 0;
        foreach (mq[i]) if (mq[i].src == s) n++;
        return n;
    endfunction

    function automatic int pick();
`ifdef CDB_ARB_PRIO0_EN
        if (mcount(0) > 0) return 0;
`endif
        for (int i = 0; i < NS; i++) begin
            int s = (rr + i) % NS;
`ifdef CDB_ARB_PRIO0_EN
            if (s == 0) continue;
`endif
            if (mcount(s) > 0) return s;
        end
        return -1;
    endfunction

    task automatic drive_and_model(input logic fl);
        logic [NS-1:0] er;
        int g;
        int hi;
        bc_t b;
        flush = fl;
        for (int s = 0; s < NS; s++) begin
            src_valid[s]          = pv[s];
            src_tag[s*TW +: TW]   = pt[s];
            src_data[s*DW +: DW]  = pd[s];
        end
        #1;
        for (int s = 0; s < NS; s++) er[s] = !fl && (mcount(s) < BD);
        check("src_ready", 64'(src_ready), 64'(er));
        if (fl) begin
            mq.delete();
            rr = 0;
        end else begin
            g = pick();
            if (g >= 0) begin
                hi = -1;
                foreach (mq[i]) if (hi < 0 && mq[i].src == g) hi = i;
                b.tag  = mq[hi].tag;
                b.data = mq[hi].data;
                b.src  = '0;
                b.src[g] = 1'b1;
                expq.push_back(b);
                mq.delete(hi);
`ifdef CDB_ARB_PRIO0_EN
                if (g != 0) rr = (g + 1) % NS;
`else
                rr = (g + 1) % NS;
`endif
            end
            for (int s = 0; s < NS; s++) begin
                if (pv[s] && er[s]) mq.push_back('{s, pt[s], pd[s]});
            end
        end
        for (int s = 0; s < NS; s++) if (pv[s] && er[s]) pv[s] = 1'b0;
    endtask

    task automatic cycle(input logic fl);
        drive_and_model(fl);
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0);
    endtask

    task automatic offer(input int s, input logic [TW-1:0] t, input logic [DW-1:0] d);
        pv[s] = 1'b1;
        pt[s] = t;
        pd[s] = d;
    endtask

    task automatic reset_mid();
        pv = '0;
        drive_and_model(1'b0);
        @(posedge i_clk);
        #2;
        check("pre_reset_valid", 64'(cdb_valid), 64'(expq.size() != 0));
        i_rst_n = 1'b0;
        #1;
        check("async_reset", {cdb_valid, cdb_src, src_ready}, '0);
        expq.delete();
        mq.delete();
        rr = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    always @(negedge i_clk) begin
        bc_t e;
        if (i_rst_n) begin
            if (cdb_valid) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL cdb_extra: got tag %h src %b, expected no broadcast", cdb_tag, cdb_src);
                end else begin
                    e = expq.pop_front();
                    check("cdb_bcast", 64'({cdb_tag, cdb_data, cdb_src}), 64'({e.tag, e.data, e.src}));
                end
            end else begin
                check("cdb_src_idle", 64'(cdb_src), 64'd0);
            end
        end
    end

    initial begin
        int fed;
        i_rst_n = 1'b0;
        flush = 1'b0;
        src_valid = '0;
        src_tag = '0;
        src_data = '0;
        pv = '0;
        rr = 0;
        for (int s = 0; s < NS; s++) begin
            pt[s] = '0;
            pd[s] = '0;
        end
        repeat (2) @(negedge i_clk);
        check("ready_in_reset", 64'(src_ready), 64'd0);
        i_rst_n = 1'b1;
        #1;
        check("reset_cdb", 64'({cdb_valid, cdb_tag, cdb_data, cdb_src}), 64'd0);

        // single push from source 2
        offer(2, 6'h15, 32'hDEAD_BEEF);
        cycle(1'b0);
        check("single_k", 64'(cdb_valid), 64'd0);
        cycle(1'b0);
        check("single_k1", 64'({cdb_valid, cdb_tag, cdb_data, cdb_src}), 64'({1'b1, 6'h15, 32'hDEAD_BEEF, 4'b0100}));
        cycle(1'b0);
        check("single_k2", 64'(cdb_valid), 64'd0);
        idle(2);

        // all sources at once from rr_ptr 0, then source 1 again
        cycle(1'b1);
        for (int s = 0; s < NS; s++) offer(s, TW'(s + 1), $urandom);
        cycle(1'b0);
        idle(1);
        offer(1, 6'h09, $urandom);
        idle(6);

        // backpressure on source 3 while 0-2 keep the bus busy
        cycle(1'b1);
        fed = 0;
        for (int c = 0; c < 12; c++) begin
            for (int s = 0; s < 3; s++) if (!pv[s]) offer(s, TW'($urandom), $urandom);
            if (!pv[3] && fed < 3) begin
                offer(3, TW'(6'h31 + fed), $urandom);
                fed++;
            end
            cycle(1'b0);
        end
        pv = '0;
        idle(10);

        // flush with results buffered and a push in the same cycle
        for (int s = 0; s < NS; s++) offer(s, TW'($urandom), $urandom);
        cycle(1'b0);
        for (int s = 0; s < NS; s++) offer(s, TW'($urandom), $urandom);
        cycle(1'b0);
        offer(0, TW'($urandom), $urandom);
        offer(3, TW'($urandom), $urandom);
        cycle(1'b0);
        cycle(1'b1);
        idle(8);

        // asynchronous reset in the middle of a drain
        for (int s = 0; s < NS; s++) offer(s, TW'($urandom), $urandom);
        cycle(1'b0);
        for (int s = 0; s < NS; s++) offer(s, TW'($urandom), $urandom);
        cycle(1'b0);
        reset_mid();
        idle(6);

        // source 0 fed every cycle while 1 and 2 each hold one result
        cycle(1'b1);
        offer(1, 6'h21, $urandom);
        offer(2, 6'h22, $urandom);
        for (int c = 0; c < 8; c++) begin
            if (!pv[0]) offer(0, TW'($urandom), $urandom);
            cycle(1'b0);
        end
        pv = '0;
        idle(10);

        // randomized traffic with occasional flushes
        for (int c = 0; c < 500; c++) begin
            for (int s = 0; s < NS; s++) begin
                if (!pv[s] && $urandom_range(0, 99) < 45) offer(s, TW'($urandom), $urandom);
            end
            cycle($urandom_range(0, 59) == 0);
        end
        pv = '0;
        idle(12);
        check("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
